opcode_sequencer: RTL and testbench

- Sits between fetch and decode; produces the 5-bit opcode stream that the decode control logic consumes.
- Passes ordinary opcodes through unchanged.
- Expands CALL, RET and RTI into internal micro-op sequences built from PUSH_PC, PUSH_FLAGS, POP_PC, POP_FLAGS and JMP_CALL.
- Injects the hardware interrupt-entry sequence at instruction boundaries, and holds fetch while a sequence is in flight.

---
 rtl/opcode_sequencer_if.sv | 32 +++
 rtl/opcode_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_opcode_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/opcode_sequencer_if.sv
// Fetch/decode-side bundle for opcode_sequencer.
// slave: sequencer side; master: fetch+decode side.
interface opcode_sequencer_if #(
  parameter int OPW = 5
);
  logic [OPW-1:0] fetch_opcode;
  logic           fetch_valid;
  logic           fetch_ready;
  logic           stall;
  logic           intr;
  logic [OPW-1:0] out_opcode;
  logic           out_valid;
  logic           pc_hold;
  logic           intr_ack;
  logic           busy;

  modport slave (
    input  fetch_opcode, fetch_valid,
    input  stall, intr,
    output fetch_ready,
    output out_opcode, out_valid,
    output pc_hold, intr_ack, busy
  );

  modport master (
    output fetch_opcode, fetch_valid,
    output stall, intr,
    input  fetch_ready,
    input  out_opcode, out_valid,
    input  pc_hold, intr_ack, busy
  );
endinterface

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: pass-through, CALL/RET/RTI expansion, interrupt entry.
// Ports: clk, rst (sync active-low), bus (opcode_sequencer_if.slave).
// Optional macro OPCODE_SEQ_INTR_MASK_EN: block nesting inside a handler.
module opcode_sequencer #(
  parameter int OPW         = 5,
  parameter int RET_BUBBLES = 2
) (
  input  logic clk,
  input  logic rst,
  opcode_sequencer_if.slave bus
);

  localparam logic [OPW-1:0] OP_NOP  = '0;
  localparam logic [OPW-1:0] OP_CALL = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_RET  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_RTI  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_JMPC = OPW'(5'b11011);
  localparam logic [OPW-1:0] OP_POPP = OPW'(5'b11100);
  localparam logic [OPW-1:0] OP_POPF = OPW'(5'b11101);
  localparam logic [OPW-1:0] OP_PSHF = OPW'(5'b11110);
  localparam logic [OPW-1:0] OP_PSHP = OPW'(5'b11111);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INT2  = 3'd1;
  localparam logic [2:0] S_INT3  = 3'd2;
  localparam logic [2:0] S_CALL2 = 3'd3;
  localparam logic [2:0] S_RTI2  = 3'd4;
  localparam logic [2:0] S_BUB   = 3'd5;

  localparam logic [1:0] BUB_INIT = 2'(RET_BUBBLES);
  localparam logic [2:0] POP_NEXT =
    (RET_BUBBLES == 0) ? S_IDLE : S_BUB;

  logic [2:0]     r_state;
  logic [1:0]     r_cnt;
  logic           r_pend;
  logic [OPW-1:0] r_op;
  logic           r_vld;
  logic           r_ack;
  logic           r_in_handler;

  logic [2:0]     w_nstate;
  logic [1:0]     w_ncnt;
  logic [OPW-1:0] w_nop;
  logic           w_nvld;
  logic           w_ack;
  logic           w_idle;
  logic           w_take;
  logic           w_accept;
  logic           w_is_call;
  logic           w_is_ret;
  logic           w_is_rti;
  logic           w_is_rsv;

  assign w_idle = (r_state == S_IDLE);

`ifdef OPCODE_SEQ_INTR_MASK_EN
  assign w_take = (r_pend | bus.intr) & ~r_in_handler;
`else
  assign r_in_handler = 1'b0;
  assign w_take = r_pend | bus.intr;
`endif

  assign bus.fetch_ready = rst & ~bus.stall & w_idle & ~w_take;
  assign w_accept = bus.fetch_valid & bus.fetch_ready;

  assign w_is_call = (bus.fetch_opcode == OP_CALL);
  assign w_is_ret  = (bus.fetch_opcode == OP_RET);
  assign w_is_rti  = (bus.fetch_opcode == OP_RTI);
  // Micro-op encodings occupy the top of the opcode space.
  assign w_is_rsv  = (bus.fetch_opcode >= OP_JMPC);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nop    = OP_NOP;
    w_nvld   = 1'b0;
    w_ack    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_nop    = OP_PSHP;
          w_nvld   = 1'b1;
          w_nstate = S_INT2;
        end else if (w_accept) begin
          w_nvld = 1'b1;
          unique case (1'b1)
            w_is_call: begin
              w_nop    = OP_PSHP;
              w_nstate = S_CALL2;
            end
            w_is_ret: begin
              w_nop    = OP_POPP;
              w_ncnt   = BUB_INIT;
              w_nstate = POP_NEXT;
            end
            w_is_rti: begin
              w_nop    = OP_POPF;
              w_nstate = S_RTI2;
            end
            w_is_rsv: w_nop = OP_NOP;
            default:  w_nop = bus.fetch_opcode;
          endcase
        end
      end
      S_INT2: begin
        w_nop    = OP_PSHF;
        w_nvld   = 1'b1;
        w_nstate = S_INT3;
      end
      S_INT3: begin
        w_nop    = OP_JMPC;
        w_nvld   = 1'b1;
        w_ack    = 1'b1;
        w_nstate = S_IDLE;
      end
      S_CALL2: begin
        w_nop    = OP_JMPC;
        w_nvld   = 1'b1;
        w_nstate = S_IDLE;
      end
      S_RTI2: begin
        w_nop    = OP_POPP;
        w_nvld   = 1'b1;
        w_ncnt   = BUB_INIT;
        w_nstate = POP_NEXT;
      end
      S_BUB: begin
        w_nop  = OP_NOP;
        w_nvld = 1'b1;
        w_ncnt = r_cnt - 2'd1;
        // <=1 also drains a zero count safely.
        if (r_cnt <= 2'd1) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_pend  <= 1'b0;
      r_op    <= OP_NOP;
      r_vld   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      // Requests latch even when stalled.
      if (!bus.stall && r_state == S_INT3)
        r_pend <= 1'b0;
      else
        r_pend <= r_pend | bus.intr;
      // Ack stays a single pulse across stalls.
      r_ack <= ~bus.stall & w_ack;
      if (!bus.stall) begin
        r_state <= w_nstate;
        r_cnt   <= w_ncnt;
        r_op    <= w_nop;
        r_vld   <= w_nvld;
      end
    end
  end

`ifdef OPCODE_SEQ_INTR_MASK_EN
  always_ff @(posedge clk) begin
    if (!rst)
      r_in_handler <= 1'b0;
    else if (!bus.stall && r_state == S_INT3)
      r_in_handler <= 1'b1;
    else if (!bus.stall && r_state == S_RTI2)
      r_in_handler <= 1'b0;
  end
`endif

  assign bus.out_opcode = r_op;
  assign bus.out_valid  = r_vld;
  assign bus.intr_ack   = r_ack;
  assign bus.busy       = ~w_idle;
  assign bus.pc_hold    = ~w_idle | w_take;

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer with an expected-opcode queue.
// Every issued op (new, unstalled) is popped and compared.
module tb_opcode_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [4:0] exp_q[$];

  opcode_sequencer_if #(.OPW(5)) bus ();

  opcode_sequencer #(.OPW(5), .RET_BUBBLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic st;
    logic rs;
    st = bus.stall;
    rs = rst;
    @(posedge clk);
    #1;
    if (rs && !st && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra observed=%0h expected=none",
               bus.out_opcode);
      end else begin
        chk("sb_op", bus.out_opcode, exp_q.pop_front());
      end
    end
  endtask

  task automatic fetch(input logic [4:0] op);
    bus.fetch_opcode = op;
    bus.fetch_valid  = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.fetch_opcode = 5'b10011;
    bus.fetch_valid  = 1'b1;
    bus.stall        = 1'b0;
    bus.intr         = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_op", bus.out_opcode, 0);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.intr_ack, 0);
    chk("rst_rdy", bus.fetch_ready, 0);
    rst = 1'b1;

    // pass-through ADD
    fetch(5'b10011);
    #1;
    chk("add_rdy", bus.fetch_ready, 1);
    exp_q.push_back(5'b10011);
    tick();
    bus.fetch_valid = 1'b0;
    chk("add_drain", exp_q.size(), 0);

    // CALL then ADD held off one cycle
    fetch(5'b01101);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11011);
    tick();
    fetch(5'b10011);
    #1;
    chk("call_rdy", bus.fetch_ready, 0);
    chk("call_hold", bus.pc_hold, 1);
    tick();
    chk("call_drain", exp_q.size(), 0);
    chk("call_rdy2", bus.fetch_ready, 1);
    exp_q.push_back(5'b10011);
    tick();
    bus.fetch_valid = 1'b0;
    chk("call_add", exp_q.size(), 0);

    // RTI with two bubbles
    fetch(5'b01111);
    exp_q.push_back(5'b11101);
    exp_q.push_back(5'b11100);
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00000);
    tick();
    bus.fetch_valid = 1'b0;
    chk("rti_busy1", bus.busy, 1);
    tick();
    chk("rti_busy2", bus.busy, 1);
    tick();
    chk("rti_busy3", bus.busy, 1);
    tick();
    chk("rti_busy4", bus.busy, 0);
    chk("rti_drain", exp_q.size(), 0);
    tick();
    chk("rti_idle_vld", bus.out_valid, 0);

    // RET
    fetch(5'b01110);
    exp_q.push_back(5'b11100);
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00000);
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    tick();
    chk("ret_busy", bus.busy, 0);
    chk("ret_drain", exp_q.size(), 0);

    // reserved micro-op from fetch
    fetch(5'b11110);
    exp_q.push_back(5'b00000);
    tick();
    bus.fetch_valid = 1'b0;
    chk("rsv_vld", bus.out_valid, 1);
    chk("rsv_busy", bus.busy, 0);

    // interrupt beats fetch of SUB
    fetch(5'b10101);
    bus.intr = 1'b1;
    #1;
    chk("irq_rdy", bus.fetch_ready, 0);
    chk("irq_hold", bus.pc_hold, 1);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11110);
    exp_q.push_back(5'b11011);
    tick();
    bus.intr = 1'b0;
    chk("irq_ack1", bus.intr_ack, 0);
    tick();
    chk("irq_ack2", bus.intr_ack, 0);
    tick();
    chk("irq_ack3", bus.intr_ack, 1);
    chk("irq_drain", exp_q.size(), 0);
    chk("irq_rdy2", bus.fetch_ready, 1);
    exp_q.push_back(5'b10101);
    tick();
    bus.fetch_valid = 1'b0;
    chk("irq_ack4", bus.intr_ack, 0);
    chk("irq_sub", exp_q.size(), 0);

    // stall mid-CALL
    fetch(5'b01101);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11011);
    tick();
    bus.fetch_valid = 1'b0;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_op", bus.out_opcode, 5'b11111);
      chk("stl_busy", bus.busy, 1);
    end
    bus.stall = 1'b0;
    tick();
    chk("stl_drain", exp_q.size(), 0);
    chk("stl_busy2", bus.busy, 0);

    // reset mid-RTI
    fetch(5'b01111);
    exp_q.push_back(5'b11101);
    tick();
    bus.fetch_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("mrst_op", bus.out_opcode, 0);
    chk("mrst_vld", bus.out_valid, 0);
    chk("mrst_busy", bus.busy, 0);
    rst = 1'b1;
    tick();
    chk("mrst_nopop", bus.out_valid, 0);
    chk("mrst_drain", exp_q.size(), 0);

    // intr during CALL waits for the boundary
    fetch(5'b01101);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11011);
    tick();
    bus.fetch_valid = 1'b0;
    bus.intr = 1'b1;
    tick();
    bus.intr = 1'b0;
    fetch(5'b10011);
    #1;
    chk("pend_rdy", bus.fetch_ready, 0);
    chk("pend_hold", bus.pc_hold, 1);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11110);
    exp_q.push_back(5'b11011);
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    tick();
    chk("pend_ack", bus.intr_ack, 1);
    chk("pend_drain", exp_q.size(), 0);

    // second request while inside the handler
    bus.intr = 1'b1;
    #1;
`ifdef OPCODE_SEQ_INTR_MASK_EN
    chk("nest_hold", bus.pc_hold, 0);
    chk("nest_rdy", bus.fetch_ready, 1);
    tick();
    bus.intr = 1'b0;
    tick();
    chk("nest_vld", bus.out_valid, 0);
    fetch(5'b01111);
    exp_q.push_back(5'b11101);
    exp_q.push_back(5'b11100);
    exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00000);
    tick();
    bus.fetch_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("nest_rti", exp_q.size(), 0);
    #1;
    chk("nest_hold2", bus.pc_hold, 1);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11110);
    exp_q.push_back(5'b11011);
    tick();
    tick();
    tick();
`else
    chk("nest_hold", bus.pc_hold, 1);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11110);
    exp_q.push_back(5'b11011);
    tick();
    bus.intr = 1'b0;
    tick();
    tick();
`endif
    chk("nest_ack", bus.intr_ack, 1);
    chk("final_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
